// File: rtl/prog_loader.sv
// Byte-stream program loader: LEN, ADDR, LEN data bytes [, CHK] become program memory writes.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state).
module prog_loader #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 START,
   input  logic [7:0]           BYTE_IN,
   input  logic                 BYTE_VALID,
   output logic                 BYTE_READY,
   output logic                 W,
   output logic [ADDR_SIZE-1:0] ADDR,
   output logic [DATA_SIZE-1:0] DATA_WR,
   output logic                 CORE_RSTN,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 ERR
);

   localparam int         CNT_W   = ADDR_SIZE + 1;
   localparam logic [8:0] MAX_LEN = 9'(2 ** ADDR_SIZE);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_LEN  = 3'd1,
      S_GET_ADDR = 3'd2,
      S_DATA     = 3'd3,
      S_WRITE    = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK    = 3'd5,
`endif
      S_DONE     = 3'd6,
      S_ERROR    = 3'd7
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [DATA_SIZE-1:0] r_data;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]           r_xor;
`endif

   logic w_accept;
   logic w_len_bad;
   logic w_last_word;

   assign w_accept    = BYTE_VALID && BYTE_READY;
   assign w_len_bad   = (BYTE_IN == 8'd0) || ({1'b0, BYTE_IN} > MAX_LEN);
   assign w_last_word = (r_cnt == CNT_W'(1));

   assign ADDR    = r_addr;
   assign DATA_WR = r_data;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output and the next state get a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      BYTE_READY   = 1'b0;
      W            = 1'b0;
      BUSY         = 1'b1;
      CORE_RSTN    = 1'b0;
      DONE         = 1'b0;
      ERR          = 1'b0;
      case (r_state)
         S_IDLE: begin
            BUSY = 1'b0;
            if (START) w_next_state = S_GET_LEN;
         end
         S_GET_LEN: begin
            BYTE_READY = 1'b1;
            if (w_accept) w_next_state = w_len_bad ? S_ERROR : S_GET_ADDR;
         end
         S_GET_ADDR: begin
            BYTE_READY = 1'b1;
            if (w_accept) w_next_state = S_DATA;
         end
         S_DATA: begin
            BYTE_READY = 1'b1;
            if (w_accept) w_next_state = S_WRITE;
         end
         S_WRITE: begin
            W = 1'b1;
            if (w_last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               w_next_state = S_CHECK;
`else
               w_next_state = S_DONE;
`endif
            end else begin
               w_next_state = S_DATA;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHECK: begin
            BYTE_READY = 1'b1;
            if (w_accept) w_next_state = (BYTE_IN == r_xor) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE: begin
            BUSY      = 1'b0;
            CORE_RSTN = 1'b1;
            DONE      = 1'b1;
            if (START) w_next_state = S_GET_LEN;
         end
         S_ERROR: begin
            BUSY = 1'b0;
            ERR  = 1'b1;
            if (START) w_next_state = S_GET_LEN;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Datapath: word counter, write address/data and (optionally) the running XOR.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt  <= '0;
         r_addr <= '0;
         r_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         r_xor  <= '0;
`endif
      end else begin
         case (r_state)
            S_GET_LEN: begin
               if (w_accept) begin
                  r_cnt <= CNT_W'(BYTE_IN);
`ifdef PROG_LOADER_CHECKSUM_EN
                  r_xor <= BYTE_IN;
`endif
               end
            end
            S_GET_ADDR: begin
               if (w_accept) begin
                  r_addr <= BYTE_IN[ADDR_SIZE-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                  r_xor  <= r_xor ^ BYTE_IN;
`endif
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_data <= DATA_SIZE'(BYTE_IN);
`ifdef PROG_LOADER_CHECKSUM_EN
                  r_xor  <= r_xor ^ BYTE_IN;
`endif
               end
            end
            S_WRITE: begin
               r_addr <= r_addr + 1'b1;
               r_cnt  <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level write model plus directed timing checks.
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          START;
   logic [7:0]    BYTE_IN;
   logic          BYTE_VALID;
   logic          BYTE_READY;
   logic          W;
   logic [AW-1:0] ADDR;
   logic [7:0]    DATA_WR;
   logic          CORE_RSTN;
   logic          BUSY;
   logic          DONE;
   logic          ERR;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   wr_t        exp_q[$];
   int         w_cyc[$];
   logic [7:0] mem_seen [DEPTH];
   logic [7:0] fd [DEPTH];
   logic [7:0] last_chk;
   wr_t        mon_e;

   prog_loader #(.DATA_SIZE(8), .ADDR_SIZE(AW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .START     (START),
      .BYTE_IN   (BYTE_IN),
      .BYTE_VALID(BYTE_VALID),
      .BYTE_READY(BYTE_READY),
      .W         (W),
      .ADDR      (ADDR),
      .DATA_WR   (DATA_WR),
      .CORE_RSTN (CORE_RSTN),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Per-cycle compare against the frame model: each W pulse must be the next expected write.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         check("core_rstn_eq_done", {31'd0, CORE_RSTN}, {31'd0, DONE});
         check("busy_with_flag", {31'd0, BUSY & (DONE | ERR)}, 32'd0);
         if (W === 1'b1) begin
            w_cyc.push_back(cyc);
            mem_seen[ADDR] = DATA_WR;
            check("ready_low_in_w", {31'd0, BYTE_READY}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_w", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("w_addr", {28'd0, ADDR}, {28'd0, mon_e.a});
               check("w_data", {24'd0, DATA_WR}, {24'd0, mon_e.d});
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_byte_ready"}, {31'd0, BYTE_READY}, 32'd0);
      check({tag, "_w"},          {31'd0, W},          32'd0);
      check({tag, "_addr"},       {28'd0, ADDR},       32'd0);
      check({tag, "_data_wr"},    {24'd0, DATA_WR},    32'd0);
      check({tag, "_core_rstn"},  {31'd0, CORE_RSTN},  32'd0);
      check({tag, "_busy"},       {31'd0, BUSY},       32'd0);
      check({tag, "_done"},       {31'd0, DONE},       32'd0);
      check({tag, "_err"},        {31'd0, ERR},        32'd0);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < DEPTH; i++) mem_seen[i] = 8'h00;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         BYTE_VALID = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
      end
      BYTE_IN    = b;
      BYTE_VALID = 1'b1;
      n = 0;
      while (BYTE_READY !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (BYTE_READY !== 1'b1) begin
         check("byte_ready_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      if (gaps) BYTE_VALID = 1'b0;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      check("start_busy",      {31'd0, BUSY},       32'd1);
      check("start_ready",     {31'd0, BYTE_READY}, 32'd1);
      check("start_done_clr",  {31'd0, DONE},       32'd0);
      check("start_err_clr",   {31'd0, ERR},        32'd0);
      check("start_core_rstn", {31'd0, CORE_RSTN},  32'd0);
   endtask

   // Sends one valid-length frame built from fd[]; queues the writes the frame implies.
   task automatic send_frame(input int len, input logic [7:0] ab, input bit gaps,
                             input bit good_chk, input bit start_mid);
      logic [7:0] x;
      wr_t        w;
      x = 8'(len) ^ ab;
      for (int i = 0; i < len; i++) begin
         w.a = AW'((int'(ab) + i) % DEPTH);
         w.d = fd[i];
         exp_q.push_back(w);
         x = x ^ fd[i];
      end
      last_chk = x;
      send_byte(8'(len), gaps);
      send_byte(ab, gaps);
      for (int i = 0; i < len; i++) begin
         if (start_mid && i == 1) begin
            START = 1'b1;
            @(posedge clk); #1;
            START = 1'b0;
            check("start_mid_ignored_busy", {31'd0, BUSY}, 32'd1);
         end
         send_byte(fd[i], gaps);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(good_chk ? x : ~x, gaps);
      BYTE_VALID = 1'b0;
      check("chk_done",      {31'd0, DONE},      {31'd0, good_chk});
      check("chk_err",       {31'd0, ERR},       {31'd0, !good_chk});
      check("chk_core_rstn", {31'd0, CORE_RSTN}, {31'd0, good_chk});
`else
      BYTE_VALID = 1'b0;
      check("last_w_cycle", {31'd0, W}, 32'd1);
      check("last_w_nodone", {31'd0, DONE}, 32'd0);
      @(posedge clk); #1;
      check("done_after_w",      {31'd0, DONE},      {31'd0, good_chk});
      check("core_rstn_after_w", {31'd0, CORE_RSTN}, {31'd0, good_chk});
      check("busy_after_w",      {31'd0, BUSY},      32'd0);
`endif
      check("writes_all_seen", exp_q.size(), 32'd0);
   endtask

   task automatic len_error(input logic [7:0] len);
      int wn;
      pulse_start();
      wn = w_cyc.size();
      send_byte(len, 1'b0);
      BYTE_VALID = 1'b0;
      check("len_err_flag",      {31'd0, ERR},       32'd1);
      check("len_err_busy",      {31'd0, BUSY},      32'd0);
      check("len_err_core_rstn", {31'd0, CORE_RSTN}, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("len_err_no_w",  w_cyc.size(), wn);
      check("len_err_held",  {31'd0, ERR}, 32'd1);
   endtask

   task automatic load_t1_data();
      fd[0] = 8'hA1;
      fd[1] = 8'hB2;
      fd[2] = 8'hC3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      wr_t w;
      rstn       = 1'b0;
      START      = 1'b0;
      BYTE_IN    = 8'h00;
      BYTE_VALID = 1'b0;
      clear_mem();
      #2;
      check_reset_vals("rst");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("idle");

      // Basic frame, VALID held high
      load_t1_data();
      clear_mem();
      w_cyc.delete();
      pulse_start();
      send_frame(3, 8'h02, 1'b0, 1'b1, 1'b0);
      check("t1_mem2", {24'd0, mem_seen[2]}, 32'h0000_00A1);
      check("t1_mem3", {24'd0, mem_seen[3]}, 32'h0000_00B2);
      check("t1_mem4", {24'd0, mem_seen[4]}, 32'h0000_00C3);
      check("t1_nwrites", w_cyc.size(), 32'd3);
      if (w_cyc.size() == 3) begin
         check("t1_spacing01", w_cyc[1] - w_cyc[0], 32'd2);
         check("t1_spacing12", w_cyc[2] - w_cyc[1], 32'd2);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      check("t1_model_chk", {24'd0, last_chk}, 32'h0000_00D1);

      // Bad checksum: words stay written, core stays in reset
      clear_mem();
      pulse_start();
      send_frame(3, 8'h02, 1'b0, 1'b0, 1'b0);
      check("t2_mem2", {24'd0, mem_seen[2]}, 32'h0000_00A1);
      check("t2_mem3", {24'd0, mem_seen[3]}, 32'h0000_00B2);
      check("t2_mem4", {24'd0, mem_seen[4]}, 32'h0000_00C3);
      @(posedge clk); #1;
      check("t2_core_rstn_low", {31'd0, CORE_RSTN}, 32'd0);
`endif

      // LEN out of range: zero and one past the memory depth
      len_error(8'h00);
      len_error(8'h11);

      // LEN equal to depth is legal and wraps through the whole memory
      for (int i = 0; i < DEPTH; i++) fd[i] = 8'(8'h40 + i);
      clear_mem();
      pulse_start();
      send_frame(16, 8'h05, 1'b0, 1'b1, 1'b0);
      check("full_mem5", {24'd0, mem_seen[5]}, 32'h0000_0040);
      check("full_mem4", {24'd0, mem_seen[4]}, 32'h0000_004F);

      // Wrap with upper ADDR-byte bits set (ignored)
      fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h44;
      clear_mem();
      pulse_start();
      send_frame(4, 8'h3E, 1'b0, 1'b1, 1'b0);
      check("wrap_mem14", {24'd0, mem_seen[14]}, 32'h0000_0011);
      check("wrap_mem15", {24'd0, mem_seen[15]}, 32'h0000_0022);
      check("wrap_mem0",  {24'd0, mem_seen[0]},  32'h0000_0033);
      check("wrap_mem1",  {24'd0, mem_seen[1]},  32'h0000_0044);

      // Backpressure with a START pulse mid-session
      load_t1_data();
      clear_mem();
      w_cyc.delete();
      pulse_start();
      send_frame(3, 8'h02, 1'b1, 1'b1, 1'b1);
      check("bp_mem2", {24'd0, mem_seen[2]}, 32'h0000_00A1);
      check("bp_mem3", {24'd0, mem_seen[3]}, 32'h0000_00B2);
      check("bp_mem4", {24'd0, mem_seen[4]}, 32'h0000_00C3);
      check("bp_nwrites", w_cyc.size(), 32'd3);

      // Reset asserted during the second W cycle
      load_t1_data();
      pulse_start();
      w.a = 4'h2;
      w.d = 8'hA1;
      exp_q.push_back(w);
      send_byte(8'h03, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hB2, 1'b0);
      check("rst_mid_w_active", {31'd0, W}, 32'd1);
      rstn       = 1'b0;
      BYTE_VALID = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      check("rst_mid_first_write", exp_q.size(), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("rst_mid_idle");
      clear_mem();
      pulse_start();
      send_frame(3, 8'h02, 1'b0, 1'b1, 1'b0);
      check("rst_rerun_mem4", {24'd0, mem_seen[4]}, 32'h0000_00C3);
      check("rst_rerun_done", {31'd0, DONE}, 32'd1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
